rowbias_sched: RTL and testbench
================================

Name: rowbias_sched

Overview:
- Shares one rowbias instance between the n tiles of a grid row.
- Arbitrates tile requests round-robin and drives the rowbias update/rqindex pins for the winner.
- Returns the resulting bus value to the winner with a one-cycle grant pulse.
- Sits between the row's tile array and its rowbias. One instance per row.

Parameters:
- w, `GRID_LEN: width of the 1-hot pool index and of the bus value.
- n, `GRID_LEN: number of requesting tiles in the row.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- req  input  n  per-tile request. Held high until that tile's grant pulse.
- tile_index  input  n*w  per-tile requested pool index. Tile i occupies bits [i*w +: w]. 1-hot. Held stable while req[i] is high.
- grant  output  n  1-hot pulse to the serviced tile. Coincides with value_valid.
- value_valid  output  1  busvalue is the serviced tile's result this cycle.
- idx_err  output  1  pulses with grant when the latched index was not 1-hot.
- rb_update  output  1  to rowbias update.
- rb_rqindex  output  w  to rowbias rqindex.
- rb_busvalue  input  w  from rowbias busvalue.
- busvalue  output  w  registered copy of rb_busvalue, presented to tiles.

Behaviour:
- Reset values:
  - grant=0, value_valid=0, idx_err=0, rb_update=0, rb_rqindex=0, busvalue=0.
  - State=IDLE. Round-robin pointer ptr=0.
- FSM states: IDLE, ISSUE, SETTLE, DONE.
  - IDLE:
    - If req==0, stay in IDLE.
    - Otherwise pick the winner: the first set bit of req at or above ptr, wrapping to bit 0.
    - Latch owner (1-hot), latch its tile_index into rb_rqindex, and compute onehot_ok = (index has exactly one bit set).
    - Go to ISSUE.
  - ISSUE:
    - rb_update = onehot_ok for exactly this cycle.
    - If onehot_ok=0, rb_update stays 0 and rowbias keeps its prior value.
    - Go to SETTLE.
  - SETTLE:
    - rowbias has now captured the value. Register rb_busvalue into busvalue.
    - Go to DONE.
  - DONE:
    - value_valid=1, grant=owner, idx_err=~onehot_ok, each for one cycle.
    - ptr = (owner position + 1) mod n.
    - Go to IDLE.
- Latency:
  - Winner-select edge to grant is 3 cycles (IDLE→ISSUE→SETTLE→DONE).
  - Back-to-back service is 4 cycles per request.
  - Request sampled in cycle t gets grant in cycle t+3 when the scheduler is idle.
- Handshake:
  - A tile drops req in the cycle after its grant.
  - If req stays high, it is treated as a new request and is eligible again in the next IDLE, behind the other pending tiles.
- Latched transaction:
  - Once latched, a transaction completes even if req falls early.
  - tile_index changes after latching are ignored.
- Simultaneous requests:
  - Only one is serviced per transaction. The others wait, with no loss and no reordering beyond the round-robin policy.
  - Fairness: with all n requesting continuously, each tile is granted exactly once per n transactions.
- ptr wraps n-1 → 0.
- Any cycle with reset=1: return to IDLE and force all outputs to their reset values, regardless of state. A transaction in flight is dropped with no grant.
- rb_rqindex holds its last value while rb_update is low.
- busvalue changes only in SETTLE.

Optional Feature:
- Macro: ROWBIAS_SCHED_FIXED_PRIO_EN.
- Defined:
  - Fixed priority: the lowest-numbered requesting tile always wins.
  - ptr is removed and never updated.
  - Starvation of high-index tiles is permitted.
- Undefined (default): round-robin as described above.
- All ports, latency and handshake are identical in both builds.

Decomposition:
- Package rowbias_pkg:
  - sched_state_e enum {IDLE, ISSUE, SETTLE, DONE}.
  - Constant SCHED_LATENCY=3.
  - Function is_onehot(w-bit) → bit.
- Sub-module rr_pick (n):
  - Inputs req and ptr. Output 1-hot winner.
  - Implementation: mask req to bits ≥ptr, take the lowest-set-bit filter. Fall back to the unmasked req lowest-set-bit filter if the masked result is zero.
  - Under ROWBIAS_SCHED_FIXED_PRIO_EN it reduces to the unmasked filter only.

Test Plan:
Bench uses n=w=4 with rowbias pool in identity order (pool[i]=1<<i).
1. Single request: req=0010, tile1 index=0100 → rb_update high 1 cycle, 0100 on rb_rqindex; 3 cycles after selection grant=0010, value_valid=1, busvalue=0100, idx_err=0.
2. All four requesting from reset, indices 0001/0010/0100/1000 held → grants in order 0001, 0010, 0100, 1000 at 4-cycle spacing, busvalue matching each index. With FIXED_PRIO_EN and req held, tile0 is granted every time.
3. Bad index: tile2 index=0110, then a prior good request set busvalue=1000 → rb_update stays 0, grant=0100, idx_err=1, busvalue=1000 unchanged.
4. Reset mid-transaction: assert reset in the SETTLE cycle → next cycle all outputs 0, state IDLE, ptr=0. Re-requested tile is serviced with standard 3-cycle latency.
5. Early drop: req=1000 selected, req dropped in ISSUE, tile_index changed to 0001 → grant=1000 still issued, busvalue equals the latched 1000.
6. Wrap: ptr=3 (tile2 just served), req=0101 → tile0 wins (wraps past 3), then tile2.

Source files
------------

// File: rtl/rowbias_pkg.sv
// rowbias_pkg
//   Shared types and helpers for the per-row rowbias scheduler.
//   - sched_state_e : scheduler FSM states (IDLE, ISSUE, SETTLE, DONE)
//   - SCHED_LATENCY : cycles from winner-select edge to grant pulse
//   - is_onehot()   : true when exactly one bit of the argument is set
//   GRID_LEN defaults to 4 when the build does not supply it.
`ifndef GRID_LEN
`define GRID_LEN 4
`endif

package rowbias_pkg;

  localparam int unsigned GRID_W        = `GRID_LEN;
  localparam int unsigned SCHED_LATENCY = 3;
  // Widest index is_onehot() accepts; narrower callers zero-extend.
  localparam int unsigned ONEHOT_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } sched_state_e;

  // Non-zero and clearing the lowest set bit leaves nothing.
  function automatic bit is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/rowbias_sched_rr_pick.sv
// rr_pick
//   Combinational winner select for the row scheduler.
//   Ports:
//     req    [n]  : pending tile requests
//     ptr    [PW] : round-robin start position (absent under fixed priority)
//     winner [n]  : 1-hot winner, zero when req is zero
//   Build option: ROWBIAS_SCHED_FIXED_PRIO_EN selects lowest-index-wins
//   priority and removes the ptr input.
module rr_pick #(
  parameter int unsigned n  = `GRID_LEN,
  parameter int unsigned PW = (n > 1) ? $clog2(n) : 1
) (
  input  logic [n-1:0]  req,
`ifndef ROWBIAS_SCHED_FIXED_PRIO_EN
  input  logic [PW-1:0] ptr,
`endif
  output logic [n-1:0]  winner
);

  // x & -x isolates the lowest set bit.
  logic [n-1:0] low_first;
  assign low_first = req & (~req + n'(1));

`ifdef ROWBIAS_SCHED_FIXED_PRIO_EN
  assign winner = low_first;
`else
  logic [n-1:0] keep;
  logic [n-1:0] masked;
  logic [n-1:0] masked_first;

  // Keep only requests at or above the pointer.
  for (genvar gi = 0; gi < n; gi++) begin : g_keep
    assign keep[gi] = (PW'(gi) >= ptr);
  end

  assign masked       = req & keep;
  assign masked_first = masked & (~masked + n'(1));
  // Nothing at or above ptr: wrap around to the lowest requester.
  assign winner       = (masked != '0) ? masked_first : low_first;
`endif

endmodule

// File: rtl/rowbias_sched.sv
// rowbias_sched
//   Shares one rowbias instance between the n tiles of a grid row. Picks a
//   requesting tile, drives the rowbias update/rqindex pins for it, captures
//   the resulting bus value and returns it with a one-cycle grant pulse.
//   Ports:
//     clock, reset      : clock and synchronous active-high reset
//     req [n]           : per-tile request, held until that tile's grant
//     tile_index [n*w]  : per-tile 1-hot pool index, tile i at [i*w +: w]
//     grant [n]         : 1-hot pulse to the serviced tile
//     value_valid       : busvalue holds the serviced tile's result
//     idx_err           : pulses with grant when the latched index was not 1-hot
//     rb_update         : to rowbias update
//     rb_rqindex [w]    : to rowbias rqindex
//     rb_busvalue [w]   : from rowbias busvalue
//     busvalue [w]      : registered copy of rb_busvalue for the tiles
//   Build option: ROWBIAS_SCHED_FIXED_PRIO_EN replaces round-robin with
//   lowest-index-wins priority; ports and timing are unchanged.
module rowbias_sched
  import rowbias_pkg::*;
#(
  parameter int unsigned w = `GRID_LEN,
  parameter int unsigned n = `GRID_LEN
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [n-1:0]   req,
  input  logic [n*w-1:0] tile_index,
  output logic [n-1:0]   grant,
  output logic           value_valid,
  output logic           idx_err,
  output logic           rb_update,
  output logic [w-1:0]   rb_rqindex,
  input  logic [w-1:0]   rb_busvalue,
  output logic [w-1:0]   busvalue
);

  sched_state_e state_q, state_d;
  logic [n-1:0] owner_q, owner_d;
  logic [w-1:0] index_q, index_d;
  logic         ok_q, ok_d;
  logic [w-1:0] busvalue_q, busvalue_d;

  logic [n-1:0] winner;
  logic [w-1:0] win_index;
  logic [w-1:0] cand_index [n];

  // Select the winner's index: every other tile's slice is masked to zero.
  for (genvar gi = 0; gi < n; gi++) begin : g_cand
    assign cand_index[gi] = tile_index[gi*w +: w] & {w{winner[gi]}};
  end

  always_comb begin
    win_index = '0;
    for (int i = 0; i < n; i++) begin
      win_index = win_index | cand_index[i];
    end
  end

`ifndef ROWBIAS_SCHED_FIXED_PRIO_EN
  localparam int unsigned PW = (n > 1) ? $clog2(n) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_pos;

  always_comb begin
    owner_pos = '0;
    for (int i = 0; i < n; i++) begin
      if (owner_q[i]) owner_pos = PW'(i);
    end
  end

  rr_pick #(.n(n)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner)
  );
`else
  rr_pick #(.n(n)) u_pick (
    .req    (req),
    .winner (winner)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      index_q    <= '0;
      ok_q       <= 1'b0;
      busvalue_q <= '0;
`ifndef ROWBIAS_SCHED_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      index_q    <= index_d;
      ok_q       <= ok_d;
      busvalue_q <= busvalue_d;
`ifndef ROWBIAS_SCHED_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    index_d     = index_q;
    ok_d        = ok_q;
    busvalue_d  = busvalue_q;
`ifndef ROWBIAS_SCHED_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    rb_update   = 1'b0;
    grant       = '0;
    value_valid = 1'b0;
    idx_err     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req != '0) begin
          // The transaction is self-contained from here on: later changes
          // to req or tile_index do not affect it.
          owner_d = winner;
          index_d = win_index;
          ok_d    = is_onehot(ONEHOT_MAX_W'(win_index));
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A malformed index never reaches rowbias, so it keeps its value.
        rb_update = ok_q;
        state_d   = SETTLE;
      end
      SETTLE: begin
        busvalue_d = rb_busvalue;
        state_d    = DONE;
      end
      DONE: begin
        grant       = owner_q;
        value_valid = 1'b1;
        idx_err     = ~ok_q;
`ifndef ROWBIAS_SCHED_FIXED_PRIO_EN
        ptr_d = (owner_pos == PW'(n - 1)) ? '0 : owner_pos + PW'(1);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences the pulses in the same cycle, so an in-flight
    // transaction can never emit a grant.
    if (reset) begin
      rb_update   = 1'b0;
      grant       = '0;
      value_valid = 1'b0;
      idx_err     = 1'b0;
    end
  end

  assign rb_rqindex = reset ? '0 : index_q;
  assign busvalue   = reset ? '0 : busvalue_q;

endmodule

// File: tb/tb_rowbias_sched.sv
module tb_rowbias_sched;
  import rowbias_pkg::*;

  localparam int N = 4;
  localparam int W = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] tile_index = '0;
  logic [N-1:0]   grant;
  logic           value_valid;
  logic           idx_err;
  logic           rb_update;
  logic [W-1:0]   rb_rqindex;
  logic [W-1:0]   rb_busvalue;
  logic [W-1:0]   busvalue;

  logic [W-1:0]   rb_val;
  logic [W-1:0]   pool [N];

  int checks = 0;
  int fails  = 0;

  rowbias_sched #(.w(W), .n(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .tile_index  (tile_index),
    .grant       (grant),
    .value_valid (value_valid),
    .idx_err     (idx_err),
    .rb_update   (rb_update),
    .rb_rqindex  (rb_rqindex),
    .rb_busvalue (rb_busvalue),
    .busvalue    (busvalue)
  );

  always #5 clock = ~clock;

  // Rowbias stand-in: pool in identity order, value changes only on update.
  function automatic logic [W-1:0] pool_lookup(input logic [W-1:0] idx);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) if (idx[i]) v = v | pool[i];
    return v;
  endfunction

  always @(posedge clock) begin
    if (reset) rb_val <= '0;
    else if (rb_update) rb_val <= pool_lookup(rb_rqindex);
  end
  assign rb_busvalue = rb_val;

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    checks++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (value_valid !== 1'b0) begin fails++; $display("FAIL reset_value_valid: got %b want 0", value_valid); end
    checks++; if (idx_err !== 1'b0) begin fails++; $display("FAIL reset_idx_err: got %b want 0", idx_err); end
    checks++; if (rb_update !== 1'b0) begin fails++; $display("FAIL reset_rb_update: got %b want 0", rb_update); end
    checks++; if (rb_rqindex !== 4'b0000) begin fails++; $display("FAIL reset_rb_rqindex: got %b want 0000", rb_rqindex); end
    checks++; if (busvalue !== 4'b0000) begin fails++; $display("FAIL reset_busvalue: got %b want 0000", busvalue); end
    checks++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); end
    reset = 1'b0;
  endtask

  task automatic test_single;
    tick;
    req = 4'b0010; tile_index = 16'h0040;
    tick;
    checks++; if (rb_update !== 1'b1) begin fails++; $display("FAIL single_update: got %b want 1", rb_update); end
    checks++; if (rb_rqindex !== 4'b0100) begin fails++; $display("FAIL single_rqindex: got %b want 0100", rb_rqindex); end
    checks++; if (value_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b want 0", value_valid); end
    tick;
    checks++; if (rb_update !== 1'b0) begin fails++; $display("FAIL single_update_width: got %b want 0", rb_update); end
    tick;
    checks++; if (grant !== 4'b0010) begin fails++; $display("FAIL single_grant: got %b want 0010", grant); end
    checks++; if (value_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", value_valid); end
    checks++; if (busvalue !== 4'b0100) begin fails++; $display("FAIL single_busvalue: got %b want 0100", busvalue); end
    checks++; if (idx_err !== 1'b0) begin fails++; $display("FAIL single_idx_err: got %b want 0", idx_err); end
    $display("txn single: grant=%b busvalue=%b idx_err=%b", grant, busvalue, idx_err);
    req = 4'b0000;
    tick;
    checks++; if (grant !== 4'b0000) begin fails++; $display("FAIL single_grant_pulse: got %b want 0000", grant); end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    req = 4'b1111; tile_index = 16'h8421;
    for (int k = 0; k < 4; k++) begin
`ifdef ROWBIAS_SCHED_FIXED_PRIO_EN
      exp = 4'b0001;
`else
      exp = 4'b0001 << k;
`endif
      tick;
      checks++; if (rb_update !== 1'b1) begin fails++; $display("FAIL rr_update[%0d]: got %b want 1", k, rb_update); end
      checks++; if (rb_rqindex !== exp) begin fails++; $display("FAIL rr_rqindex[%0d]: got %b want %b", k, rb_rqindex, exp); end
      tick; tick;
      checks++; if (grant !== exp) begin fails++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant, exp); end
      checks++; if (busvalue !== exp) begin fails++; $display("FAIL rr_busvalue[%0d]: got %b want %b", k, busvalue, exp); end
      $display("txn rr[%0d]: grant=%b busvalue=%b", k, grant, busvalue);
      if (k == 3) req = 4'b0000;
      tick;
    end
  endtask

  task automatic test_bad_index;
    tick;
    req = 4'b1000; tile_index = 16'h8000;
    tick; tick; tick;
    checks++; if (grant !== 4'b1000) begin fails++; $display("FAIL bad_prior_grant: got %b want 1000", grant); end
    checks++; if (busvalue !== 4'b1000) begin fails++; $display("FAIL bad_prior_busvalue: got %b want 1000", busvalue); end
    $display("txn bad_prior: grant=%b busvalue=%b", grant, busvalue);
    req = 4'b0000;
    tick;
    req = 4'b0100; tile_index = 16'h0600;
    tick;
    checks++; if (rb_update !== 1'b0) begin fails++; $display("FAIL bad_update: got %b want 0", rb_update); end
    checks++; if (rb_rqindex !== 4'b0110) begin fails++; $display("FAIL bad_rqindex: got %b want 0110", rb_rqindex); end
    tick; tick;
    checks++; if (grant !== 4'b0100) begin fails++; $display("FAIL bad_grant: got %b want 0100", grant); end
    checks++; if (idx_err !== 1'b1) begin fails++; $display("FAIL bad_idx_err: got %b want 1", idx_err); end
    checks++; if (busvalue !== 4'b1000) begin fails++; $display("FAIL bad_busvalue: got %b want 1000", busvalue); end
    $display("txn bad: grant=%b busvalue=%b idx_err=%b", grant, busvalue, idx_err);
    req = 4'b0000;
    tick;
    checks++; if (idx_err !== 1'b0) begin fails++; $display("FAIL bad_idx_err_pulse: got %b want 0", idx_err); end
  endtask

  task automatic test_wrap;
    tick;
    req = 4'b0101; tile_index = 16'h0401;
    tick; tick; tick;
    checks++; if (grant !== 4'b0001) begin fails++; $display("FAIL wrap_grant0: got %b want 0001", grant); end
    checks++; if (busvalue !== 4'b0001) begin fails++; $display("FAIL wrap_busvalue0: got %b want 0001", busvalue); end
    $display("txn wrap0: grant=%b busvalue=%b", grant, busvalue);
    req = 4'b0100;
    tick;
    tick; tick; tick;
    checks++; if (grant !== 4'b0100) begin fails++; $display("FAIL wrap_grant1: got %b want 0100", grant); end
    checks++; if (busvalue !== 4'b0100) begin fails++; $display("FAIL wrap_busvalue1: got %b want 0100", busvalue); end
    $display("txn wrap1: grant=%b busvalue=%b", grant, busvalue);
    req = 4'b0000;
    tick;
  endtask

  task automatic test_reset_mid;
    tick;
    req = 4'b0010; tile_index = 16'h0020;
    tick; tick;
    checks++; if (dut.state_q !== SETTLE) begin fails++; $display("FAIL mid_in_settle: got %0d want %0d", dut.state_q, SETTLE); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin fails++; $display("FAIL mid_grant: got %b want 0000", grant); end
    checks++; if (value_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b want 0", value_valid); end
    checks++; if (rb_rqindex !== 4'b0000) begin fails++; $display("FAIL mid_rqindex: got %b want 0000", rb_rqindex); end
    checks++; if (busvalue !== 4'b0000) begin fails++; $display("FAIL mid_busvalue: got %b want 0000", busvalue); end
    checks++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL mid_state: got %0d want %0d", dut.state_q, IDLE); end
`ifndef ROWBIAS_SCHED_FIXED_PRIO_EN
    checks++; if (dut.ptr_q !== 2'd0) begin fails++; $display("FAIL mid_ptr: got %0d want 0", dut.ptr_q); end
`endif
    tick; tick;
    checks++; if (value_valid !== 1'b0) begin fails++; $display("FAIL mid_early_valid: got %b want 0", value_valid); end
    tick;
    checks++; if (grant !== 4'b0010) begin fails++; $display("FAIL mid_regrant: got %b want 0010", grant); end
    checks++; if (busvalue !== 4'b0010) begin fails++; $display("FAIL mid_rebusvalue: got %b want 0010", busvalue); end
    $display("txn reset_mid: grant=%b busvalue=%b", grant, busvalue);
    req = 4'b0000;
    tick;
  endtask

  task automatic test_early_drop;
    tick;
    req = 4'b1000; tile_index = 16'h8000;
    tick;
    req = 4'b0000; tile_index = 16'h1000;
    tick;
    checks++; if (rb_rqindex !== 4'b1000) begin fails++; $display("FAIL drop_rqindex: got %b want 1000", rb_rqindex); end
    tick;
    checks++; if (grant !== 4'b1000) begin fails++; $display("FAIL drop_grant: got %b want 1000", grant); end
    checks++; if (busvalue !== 4'b1000) begin fails++; $display("FAIL drop_busvalue: got %b want 1000", busvalue); end
    $display("txn early_drop: grant=%b busvalue=%b", grant, busvalue);
    tick; tick;
    checks++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL drop_idle: got %0d want %0d", dut.state_q, IDLE); end
    checks++; if (value_valid !== 1'b0) begin fails++; $display("FAIL drop_no_extra: got %b want 0", value_valid); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) pool[i] = W'(1 << i);
    test_reset;
    test_single;
    test_round_robin;
    test_bad_index;
    test_wrap;
    test_reset_mid;
    test_early_drop;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
